// File: rtl/spi_pkg.sv
// Shared constants for the SPI clock generator: FSM state encoding and default sizing.
package spi_pkg;

  localparam int NUM_CS_DEF = 4;
  localparam int DIV_W_DEF  = 8;
  localparam int LEN_W_DEF  = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Half-period down-counter: loads D-1, counts while run, tc is a one-cycle pulse at zero.
// Auto-reloads from load_val on tc so consecutive half-periods need no extra load.
module spi_halfper_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tc = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run) begin
      cnt_d = tc ? load_val : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master sclk/cs_n/strobe generator; registered outputs, frame begins the cycle after start, start ignored while busy.
// Defining SPI_SCLK_GEN_CS_SETUP_EN adds a D-cycle chip-select setup (LEAD) phase before the first edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int  NUM_CS = NUM_CS_DEF,
  parameter int  DIV_W  = DIV_W_DEF,
  parameter int  LEN_W  = LEN_W_DEF,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CS_W-1:0]   cfg_cs,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              shift_stb,
  output logic              sample_stb,
  output logic              done
);

  logic [1:0]        state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    edge_q, edge_d;
  logic              sclk_q, sclk_d, busy_q, busy_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              shift_q, shift_d, sample_q, sample_d, done_q, done_d;
  logic              cnt_load, cnt_run, tc;
  logic              odd_edge, last_edge;

  // edge_q counts edges already emitted, so the upcoming edge is odd when edge_q is even
  assign odd_edge  = ~edge_q[0];
  assign last_edge = (edge_q == {len_q, 1'b1});
  assign cnt_run   = (state_q != ST_IDLE);

  spi_halfper_cnt #(.DIV_W(DIV_W)) u_halfper (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (div_d),
    .run      (cnt_run),
    .tc       (tc)
  );

  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    len_d    = len_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cpol_d   = cfg_cpol;
          cpha_d   = cfg_cpha;
          div_d    = cfg_div;
          len_d    = cfg_len;
          edge_d   = '0;
          sclk_d   = cfg_cpol;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          cs_n_d   = '1;
          for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cfg_cs) == i) cs_n_d[i] = 1'b0;
          end
`ifdef SPI_SCLK_GEN_CS_SETUP_EN
          state_d = ST_LEAD;
`else
          state_d = ST_XFER;
          shift_d = ~cfg_cpha;
`endif
        end
      end
`ifdef SPI_SCLK_GEN_CS_SETUP_EN
      ST_LEAD: begin
        if (tc) begin
          state_d = ST_XFER;
          shift_d = ~cpha_q;
        end
      end
`endif
      ST_XFER: begin
        if (tc) begin
          sclk_d = ~sclk_q;
          if (cpha_q) begin
            shift_d  = odd_edge;
            sample_d = ~odd_edge;
          end else begin
            sample_d = odd_edge;
            shift_d  = ~odd_edge && ~last_edge;
          end
          if (last_edge) state_d = ST_TRAIL;
          else           edge_d  = edge_q + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (tc) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cs_n_d  = '1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      len_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= '1;
      busy_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      len_q    <= len_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign shift_stb  = shift_q;
  assign sample_stb = sample_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: per-cycle timing model derived from frame start time plus directed literal checks.
module tb_spi_sclk_gen;

  localparam int NUM_CS = 5;
  localparam int DIV_W  = 8;
  localparam int LEN_W  = 5;
  localparam int CS_W   = 3;
`ifdef SPI_SCLK_GEN_CS_SETUP_EN
  localparam int LEADF = 1;
`else
  localparam int LEADF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              cfg_cpol = 1'b0;
  logic              cfg_cpha = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [CS_W-1:0]   cfg_cs = '0;
  logic              busy, sclk, shift_stb, sample_stb, done;
  logic [NUM_CS-1:0] cs_n;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  spi_sclk_gen #(.NUM_CS(NUM_CS), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_cpol   (cfg_cpol),
    .cfg_cpha   (cfg_cpha),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
    .cfg_cs     (cfg_cs),
    .busy       (busy),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .shift_stb  (shift_stb),
    .sample_stb (sample_stb),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    logic              busy;
    logic              sclk;
    logic [NUM_CS-1:0] cs_n;
    logic              shs;
    logic              sms;
    logic              dn;
  } exp_t;

  // Expected outputs r cycles after the cycle in which start was accepted.
  function automatic exp_t model(int r, bit cpol, bit cpha, int d, int n, int cs);
    exp_t e;
    int   ent, dn_r, k;
    bit   edg;
    e      = '0;
    e.cs_n = '1;
    e.sclk = cpol;
    ent    = 1 + LEADF * d;
    dn_r   = ent + 2 * n * d + d;
    e.dn   = (r == dn_r);
    if (r >= 1 && r < dn_r) begin
      e.busy = 1'b1;
      if (cs < NUM_CS) e.cs_n[cs] = 1'b0;
      k   = (r < ent) ? 0 : (r - ent) / d;
      edg = (r > ent) && ((r - ent) % d == 0) && (k <= 2 * n);
      if (k > 2 * n) k = 2 * n;
      e.sclk = cpol ^ k[0];
      if (cpha) begin
        e.shs = edg && k[0];
        e.sms = edg && !k[0];
      end else begin
        e.sms = edg && k[0];
        e.shs = (r == ent) || (edg && !k[0] && (k != 2 * n));
      end
    end
    return e;
  endfunction

  bit fv = 0, armed = 0, idle_sclk = 0;
  bit f_cpol, f_cpha;
  int fT, f_d, f_n, f_cs;

  always @(negedge clk) begin
    exp_t e;
    if (fv) begin
      e = model(cyc - fT, f_cpol, f_cpha, f_d, f_n, f_cs);
    end else begin
      e      = '0;
      e.cs_n = '1;
      e.sclk = idle_sclk;
    end
    if (armed) begin
      chk("busy", busy, e.busy);
      chk("sclk", sclk, e.sclk);
      chk("cs_n", cs_n, e.cs_n);
      chk("shift_stb", shift_stb, e.shs);
      chk("sample_stb", sample_stb, e.sms);
      chk("done", done, e.dn);
    end
    if (!rst) begin
      fv        = 0;
      idle_sclk = 0;
      armed     = 1;
    end else if (start && !e.busy) begin
      fv     = 1;
      fT     = cyc;
      f_cpol = cfg_cpol;
      f_cpha = cfg_cpha;
      f_d    = int'(cfg_div) + 1;
      f_n    = int'(cfg_len) + 1;
      f_cs   = int'(cfg_cs);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic look(input int c);
    to_cycle(c);
    @(negedge clk);
  endtask

  task automatic setcfg(input bit p, input bit h, input int dv, input int ln, input int cs);
    cfg_cpol = p;
    cfg_cpha = h;
    cfg_div  = DIV_W'(dv);
    cfg_len  = LEN_W'(ln);
    cfg_cs   = CS_W'(cs);
  endtask

  initial begin
    int T, P, L, nsamp, cslow;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    look(cyc);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs_n", cs_n, 5'b11111);
    step();

    // cpol0 cpha0 div3 len7 cs0
    setcfg(0, 0, 3, 7, 0); start = 1'b1; T = cyc; step(); start = 1'b0;
    L = LEADF * 4;
    look(T + 1);      chk("r035_cs_n", cs_n, 5'b11110); chk("r035_busy", busy, 1'b1);
    look(T + 4 + L);  chk("r035_sclk_pre", sclk, 1'b0);
    look(T + 5 + L);  chk("r035_sclk_rise", sclk, 1'b1);
    look(T + 64 + L); chk("r035_sclk_e15", sclk, 1'b1);
    look(T + 65 + L); chk("r035_sclk_e16", sclk, 1'b0);
    look(T + 68 + L); chk("r035_done_early", done, 1'b0);
    look(T + 69 + L); chk("r035_done", done, 1'b1); chk("r035_cs_off", cs_n, 5'b11111);
    to_cycle(T + 72 + L);

    // cpol1 cpha1 div0 len0
    setcfg(1, 1, 0, 0, 0); start = 1'b1; T = cyc; step(); start = 1'b0;
    L = LEADF;
    look(T + 1 + L); chk("r036_sclk_idle", sclk, 1'b1);
    look(T + 2 + L); chk("r036_sclk_e1", sclk, 1'b0); chk("r036_shift", shift_stb, 1'b1);
    chk("r036_nosample", sample_stb, 1'b0);
    look(T + 3 + L); chk("r036_sclk_e2", sclk, 1'b1); chk("r036_sample", sample_stb, 1'b1);
    look(T + 4 + L); chk("r036_done", done, 1'b1);
    to_cycle(T + 7 + L);

    // start held high, mid-frame cfg change
    setcfg(0, 0, 1, 3, 2); start = 1'b1; T = cyc; P = 19 + 2 * LEADF;
    to_cycle(T + 5);  setcfg(1, 1, 7, 0, 0);
    to_cycle(T + 10); setcfg(0, 0, 1, 3, 2);
    look(T + P - 1);  chk("r037_done_early", done, 1'b0); chk("r037_cs_on", cs_n, 5'b11011);
    look(T + P);      chk("r037_done1", done, 1'b1); chk("r037_gap", cs_n, 5'b11111);
    look(T + P + 1);  chk("r037_cs_again", cs_n, 5'b11011); chk("r037_busy", busy, 1'b1);
    look(T + 2 * P);  chk("r037_done2", done, 1'b1);
    to_cycle(T + 2 * P + 1); start = 1'b0;
    to_cycle(T + 3 * P + 3);

    // reset at 10th edge of an 8-bit frame
    setcfg(1, 0, 1, 7, 1); start = 1'b1; T = cyc; step(); start = 1'b0;
    L = 2 * LEADF;
    to_cycle(T + 21 + L); rst = 1'b0;
    @(negedge clk); chk("r038_sclk_e10", sclk, 1'b1); chk("r038_shift_e10", shift_stb, 1'b1);
    to_cycle(T + 22 + L); rst = 1'b1;
    @(negedge clk);
    chk("r038_cs_n", cs_n, 5'b11111); chk("r038_sclk", sclk, 1'b0);
    chk("r038_busy", busy, 1'b0); chk("r038_done", done, 1'b0);
    to_cycle(T + 30 + L);

    // top chip select, then out-of-range chip select
    setcfg(0, 0, 0, 1, NUM_CS - 1); start = 1'b1; T = cyc; step(); start = 1'b0;
    look(T + 1); chk("r039_cs_top", cs_n, 5'b01111);
    to_cycle(T + 10);
    setcfg(0, 0, 0, 3, 6); start = 1'b1; T = cyc; step(); start = 1'b0;
    nsamp = 0;
    cslow = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) nsamp++;
      if (cs_n !== 5'b11111) cslow++;
      step();
    end
    chk("r039_samples", nsamp, 4);
    chk("r039_cs_low_cycles", cslow, 0);

    repeat (3000) begin
      step();
      start    = ($urandom_range(0, 2) == 0);
      cfg_cpol = 1'($urandom_range(0, 1));
      cfg_cpha = 1'($urandom_range(0, 1));
      cfg_div  = DIV_W'($urandom_range(0, 5));
      cfg_len  = LEN_W'($urandom_range(0, 7));
      cfg_cs   = CS_W'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 299) != 0);
    end
    step();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter NUM_CS, default 4, number of chip-select lines (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, width of the half-period divider field.
REQ-003 SHALL have parameter LEN_W, default 5, width of the bit-count field (max 2^LEN_W bits per frame).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  input  1  frame request; accepted only in a cycle where busy=0.
REQ-007 SHALL have port cfg_cpol  input  1  idle level of sclk.
REQ-008 SHALL have port cfg_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-009 SHALL have port cfg_div  input  DIV_W  half-period length D = cfg_div+1 clk cycles.
REQ-010 SHALL have port cfg_len  input  LEN_W  frame length N = cfg_len+1 bits.
REQ-011 SHALL have port cfg_cs  input  $clog2(NUM_CS)  target chip-select index.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port sclk  output  1  SPI serial clock.
REQ-014 SHALL have port cs_n  output  NUM_CS  active-low chip selects, one-hot-low when active.
REQ-015 SHALL have port shift_stb  output  1  one-cycle pulse: data launch point.
REQ-016 SHALL have port sample_stb  output  1  one-cycle pulse: data capture point.
REQ-017 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-018 SHALL implement FSM IDLE, LEAD (macro only), XFER, TRAIL; all outputs registered.
REQ-019 SHALL, on start with busy=0 at cycle T, latch all cfg_* and at T+1 enter XFER (or LEAD), assert busy and drive cs_n[cfg_cs]=0.
REQ-020 SHALL ignore start and cfg_* changes while busy=1.
REQ-021 SHALL hold sclk=latched cpol in IDLE, LEAD, TRAIL; in XFER toggle sclk every D cycles, 2N edges total, k-th edge at XFER-entry+k*D.
REQ-022 SHALL, with cpha=0, pulse sample_stb on odd edges, shift_stb on XFER entry cycle and on even edges except the last (N pulses each).
REQ-023 SHALL, with cpha=1, pulse shift_stb on odd edges and sample_stb on even edges (N pulses each); strobes coincide with the sclk edge cycle.
REQ-024 SHALL after the 2N-th edge enter TRAIL for D cycles, then deassert all cs_n, drop busy and pulse done in the same cycle (back to IDLE).
REQ-025 SHALL accept a start sampled in the done cycle, giving one cycle of cs_n high between frames.
REQ-026 SHALL, with cfg_div=0, toggle sclk every clk cycle (D=1).
REQ-027 SHALL, with cfg_cs >= NUM_CS, run the frame normally with all cs_n held high.
REQ-028 SHALL use saturating-free counters sized DIV_W and LEN_W+1; no wrap occurs for any legal configuration.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, force IDLE, busy=0, sclk=0, cs_n=all ones, shift_stb=sample_stb=done=0, counters=0.
REQ-030 SHALL abort a frame on mid-frame reset without a done pulse; after reset release sclk stays 0 until the next start latches cpol.

Configuration
REQ-031 SHALL, with SPI_SCLK_GEN_CS_SETUP_EN defined, insert LEAD state: cs_n asserted for D cycles before XFER begins, shifting all edges, strobes and done by D cycles.
REQ-032 SHALL, without SPI_SCLK_GEN_CS_SETUP_EN, omit LEAD entirely (IDLE goes directly to XFER).

Structure
REQ-033 SHALL place FSM state encoding and default NUM_CS/DIV_W/LEN_W constants in shared package spi_pkg.
REQ-034 SHALL implement the half-period divider as sub-module spi_halfper_cnt (load D, count, emit one-cycle terminal pulse).

Verification
REQ-035 SHALL cover: cpol=0 cpha=0 div=3 len=7 cs=0, start at cycle 0 -> cs_n[0] low at 1, rising sclk at 5, 16 edges last at 65, done at 69 (73 with macro).
REQ-036 SHALL cover: cpol=1 cpha=1 div=0 len=0 -> sclk 1->0->1 at cycles 2,3; shift_stb at 2, sample_stb at 3, done at 4.
REQ-037 SHALL cover: start held high continuously, len=3 div=1 -> back-to-back frames, cs_n high exactly one cycle between them, cfg change mid-frame ignored.
REQ-038 SHALL cover: rst=0 at 10th edge of an 8-bit frame -> next cycle cs_n=all ones, sclk=0, busy=0, no done.
REQ-039 SHALL cover: cfg_cs=NUM_CS-1 then cfg_cs out of range -> only cs_n[NUM_CS-1] low, then no cs_n low but N sample_stb pulses.
